// File: rtl/project_select_pkg.sv
// Shared definitions for the project select controller: FSM encoding,
// register offsets and register field positions.
package project_select_pkg;

  // Encoding is software-visible through STATUS[9:8].
  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StGuard = 2'd1,
    StOn    = 2'd2
  } sel_state_e;

  // Byte offsets from the block base address.
  localparam logic [3:0] OffsCtrl   = 4'h0;
  localparam logic [3:0] OffsStatus = 4'h4;
  localparam logic [3:0] OffsGuard  = 4'h8;
  localparam logic [3:0] OffsActive = 4'hC;

  // CTRL fields.
  localparam int unsigned CtrlIdxLsb = 0;
  localparam int unsigned CtrlIdxW   = 5;
  localparam int unsigned CtrlEnBit  = 7;

  // STATUS fields.
  localparam int unsigned StatusIdxLsb   = 0;
  localparam int unsigned StatusOnBit    = 7;
  localparam int unsigned StatusStateLsb = 8;
  localparam int unsigned StatusErrBit   = 16;

  // Word index of a byte offset inside the 16-byte window.
  function automatic logic [1:0] reg_word(input logic [3:0] offs);
    return offs[3:2];
  endfunction

endpackage

// File: rtl/project_select_wb_regs.sv
// Wishbone slave for the project select controller: address decode, single
// cycle registered ack, CTRL/GUARD registers, sticky error flag and read mux.
module project_select_wb_regs
  import project_select_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int unsigned NUM_PROJECTS  = 3,
  parameter int unsigned DEFAULT_GUARD = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [1:0]  state,
  input  logic [4:0]  cur_idx,
  input  logic [31:0] active,
  output logic        ctrl_wr,
  output logic        wr_en,
  output logic [4:0]  ctrl_idx,
  output logic        ctrl_en,
  output logic [7:0]  guard_len
);

  localparam logic [1:0] WordCtrl   = reg_word(OffsCtrl);
  localparam logic [1:0] WordStatus = reg_word(OffsStatus);
  localparam logic [1:0] WordGuard  = reg_word(OffsGuard);
  localparam logic [1:0] WordActive = reg_word(OffsActive);

  logic        ack_q;
  logic [31:0] dat_q;
  logic [4:0]  idx_q;
  logic        en_q;
  logic [7:0]  guard_q;
  logic        err_q;

  logic        hit, req, wr;
  logic [1:0]  word;
  logic [4:0]  wr_idx;
  logic        idx_bad;
  logic        err_set, err_clr, guard_wr;
  logic [31:0] rdata;
  logic        unused_bits;

  assign hit  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // Ack blocks a new request, so back-to-back strobes ack every second cycle.
  assign req  = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
  assign wr   = req & wbs_we_i & wbs_sel_i[0];
  assign word = wbs_adr_i[3:2];

  assign wr_idx  = wbs_dat_i[CtrlIdxLsb +: CtrlIdxW];
  assign wr_en   = wbs_dat_i[CtrlEnBit];
  assign idx_bad = wr_en && ((wr_idx == 5'd0) || ({27'd0, wr_idx} > 32'(NUM_PROJECTS)));

  assign ctrl_wr  = wr && (word == WordCtrl) && !idx_bad;
  assign err_set  = wr && (word == WordCtrl) && idx_bad;
  assign err_clr  = wr && (word == WordStatus);
  assign guard_wr = wr && (word == WordGuard);

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

  // Read mux over the current register contents.
  always_comb begin
    rdata = '0;
    unique case (word)
      WordCtrl: begin
        rdata[CtrlIdxLsb +: CtrlIdxW] = idx_q;
        rdata[CtrlEnBit]              = en_q;
      end
      WordStatus: begin
        rdata[StatusIdxLsb +: 5]   = cur_idx;
        rdata[StatusOnBit]         = (state == StOn);
        rdata[StatusStateLsb +: 2] = state;
        rdata[StatusErrBit]        = err_q;
      end
      WordGuard:  rdata[7:0] = guard_q;
      WordActive: rdata      = active;
      default:    rdata      = '0;
    endcase
  end

  // Ack, read data and register file updates at the request edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      guard_q <= 8'(DEFAULT_GUARD);
      err_q   <= 1'b0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wbs_we_i) ? rdata : '0;
      if (ctrl_wr) begin
        idx_q <= wr_idx;
        en_q  <= wr_en;
      end
      // A zero guard would skip the all-off interval, so it is stored as 1.
      if (guard_wr) guard_q <= (wbs_dat_i[7:0] == 8'd0) ? 8'd1 : wbs_dat_i[7:0];
      if (err_set) err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign ctrl_idx  = idx_q;
  assign ctrl_en   = en_q;
  assign guard_len = guard_q;

endmodule

// File: rtl/project_select_ctrl.sv
// Drives the one-hot project enable. Every change of project passes through
// an all-off guard interval, and each activation gets a short reset pulse.
module project_select_ctrl
  import project_select_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int unsigned NUM_PROJECTS  = 3,
  parameter int unsigned DEFAULT_GUARD = 8,
  parameter int unsigned RST_LEN       = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] active,
  output logic        proj_rst_n
);

  sel_state_e state_q, state_d;
  logic [7:0] gcnt_q, gcnt_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [4:0] cur_idx_q, cur_idx_d;

  logic       ctrl_wr, wr_en, ctrl_en;
  logic [4:0] ctrl_idx;
  logic [7:0] guard_len;

  project_select_wb_regs #(
    .BASE_ADDR     (BASE_ADDR),
    .NUM_PROJECTS  (NUM_PROJECTS),
    .DEFAULT_GUARD (DEFAULT_GUARD)
  ) u_regs (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .state     (state_q),
    .cur_idx   (cur_idx_q),
    .active    (active),
    .ctrl_wr   (ctrl_wr),
    .wr_en     (wr_en),
    .ctrl_idx  (ctrl_idx),
    .ctrl_en   (ctrl_en),
    .guard_len (guard_len)
  );

  // Next state, guard countdown and reset pulse countdown.
  always_comb begin
    state_d   = state_q;
    gcnt_d    = gcnt_q;
    rcnt_d    = rcnt_q;
    cur_idx_d = cur_idx_q;
    unique case (state_q)
      StOff: begin
        if (ctrl_wr && wr_en) begin
          state_d = StGuard;
          gcnt_d  = guard_len;
        end
      end
      StGuard: begin
        if (ctrl_wr) begin
          gcnt_d = guard_len;
        end else if (gcnt_q == 8'd0) begin
          if (ctrl_en) begin
            state_d   = StOn;
            cur_idx_d = ctrl_idx;
            rcnt_d    = 4'(RST_LEN);
          end else begin
            state_d = StOff;
          end
        end else begin
          gcnt_d = gcnt_q - 8'd1;
        end
      end
      StOn: begin
        // Any accepted CTRL write, even a same-index rewrite, drops active.
        if (ctrl_wr) begin
          state_d = StGuard;
          gcnt_d  = guard_len;
          rcnt_d  = 4'd0;
        end else if (rcnt_q != 4'd0) begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      default: state_d = StOff;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= StOff;
      gcnt_q    <= '0;
      rcnt_q    <= '0;
      cur_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      gcnt_q    <= gcnt_d;
      rcnt_q    <= rcnt_d;
      cur_idx_q <= cur_idx_d;
    end
  end

  // Outputs decode straight from registers so reset clears them at once.
  always_comb begin
    active     = (state_q == StOn) ? (32'd1 << cur_idx_q) : 32'd0;
    proj_rst_n = !((state_q == StOn) && (rcnt_q != 4'd0));
  end

endmodule
